// File: rtl/control_dispensado.sv
// Drink valve sequencer: latches per-ingredient times on start, then opens
// agua, cafe, leche, chocolate and azucar valves one after another.
module control_dispensado #(
    parameter int CYCLES_PER_UNIT = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cancel,
    input  logic [1:0] t_agua,
    input  logic [1:0] t_cafe,
    input  logic [1:0] t_leche,
    input  logic [1:0] t_chocolate,
    input  logic [1:0] t_azucar,
    output logic       v_agua,
    output logic       v_cafe,
    output logic       v_leche,
    output logic       v_chocolate,
    output logic       v_azucar,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] etapa
);

    localparam int PW = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CYCLES_PER_UNIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_AGUA      = 3'd1,
        ST_CAFE      = 3'd2,
        ST_LECHE     = 3'd3,
        ST_CHOCOLATE = 3'd4,
        ST_AZUCAR    = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [1:0]    unit, unit_n;
    logic [1:0]    l_agua, l_cafe, l_leche, l_choc, l_azucar;
    logic [1:0]    l_agua_n, l_cafe_n, l_leche_n, l_choc_n, l_azucar_n;
    logic          err_q, err_n;
    logic [1:0]    t_cur;
    logic          stage_end;
    logic          any_t;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            presc    <= '0;
            unit     <= '0;
            l_agua   <= '0;
            l_cafe   <= '0;
            l_leche  <= '0;
            l_choc   <= '0;
            l_azucar <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            presc    <= presc_n;
            unit     <= unit_n;
            l_agua   <= l_agua_n;
            l_cafe   <= l_cafe_n;
            l_leche  <= l_leche_n;
            l_choc   <= l_choc_n;
            l_azucar <= l_azucar_n;
            err_q    <= err_n;
        end
    end

    always_comb begin
        t_cur = 2'd0;
        case (state)
            ST_AGUA:      t_cur = l_agua;
            ST_CAFE:      t_cur = l_cafe;
            ST_LECHE:     t_cur = l_leche;
            ST_CHOCOLATE: t_cur = l_choc;
            ST_AZUCAR:    t_cur = l_azucar;
            default:      t_cur = 2'd0;
        endcase
    end

    // A zero-time stage still occupies one cycle, valve closed
    assign stage_end = (t_cur == 2'd0) ||
                       ((presc == PMAX) && (unit == t_cur - 2'd1));
    assign any_t = |{t_agua, t_cafe, t_leche, t_chocolate, t_azucar};

    always_comb begin
        state_n    = state;
        presc_n    = presc;
        unit_n     = unit;
        l_agua_n   = l_agua;
        l_cafe_n   = l_cafe;
        l_leche_n  = l_leche;
        l_choc_n   = l_choc;
        l_azucar_n = l_azucar;
        err_n      = 1'b0;
        case (state)
            ST_IDLE: begin
                presc_n = '0;
                unit_n  = '0;
                if (start && !cancel) begin
                    if (any_t) begin
                        l_agua_n   = t_agua;
                        l_cafe_n   = t_cafe;
                        l_leche_n  = t_leche;
                        l_choc_n   = t_chocolate;
                        l_azucar_n = t_azucar;
                        state_n    = ST_AGUA;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_AGUA, ST_CAFE, ST_LECHE, ST_CHOCOLATE, ST_AZUCAR: begin
                if (cancel) begin
                    state_n = ST_IDLE;
                    presc_n = '0;
                    unit_n  = '0;
                end else if (stage_end) begin
                    state_n = state_t'(state + 3'd1);
                    presc_n = '0;
                    unit_n  = '0;
                end else if (presc == PMAX) begin
                    presc_n = '0;
                    unit_n  = unit + 2'd1;
                end else begin
                    presc_n = presc + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                presc_n = '0;
                unit_n  = '0;
            end
        endcase
    end

    assign v_agua      = (state == ST_AGUA)      && (l_agua   != 2'd0);
    assign v_cafe      = (state == ST_CAFE)      && (l_cafe   != 2'd0);
    assign v_leche     = (state == ST_LECHE)     && (l_leche  != 2'd0);
    assign v_chocolate = (state == ST_CHOCOLATE) && (l_choc   != 2'd0);
    assign v_azucar    = (state == ST_AZUCAR)    && (l_azucar != 2'd0);
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign err         = err_q;
    assign etapa       = state;

endmodule

// File: tb/tb_control_dispensado.sv
// Directed bench for control_dispensado with a unit of 4 clock cycles.
module tb_control_dispensado;

    localparam int CPU = 4;

    logic       clk = 1'b0;
    logic       rst, start, cancel;
    logic [1:0] tin [5];
    logic       v_agua, v_cafe, v_leche, v_chocolate, v_azucar;
    logic       busy, done, err;
    logic [2:0] etapa;
    logic [4:0] vals;

    int n_tests = 0;
    int n_fail  = 0;

    control_dispensado #(.CYCLES_PER_UNIT(CPU)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cancel(cancel),
        .t_agua(tin[0]),
        .t_cafe(tin[1]),
        .t_leche(tin[2]),
        .t_chocolate(tin[3]),
        .t_azucar(tin[4]),
        .v_agua(v_agua),
        .v_cafe(v_cafe),
        .v_leche(v_leche),
        .v_chocolate(v_chocolate),
        .v_azucar(v_azucar),
        .busy(busy),
        .done(done),
        .err(err),
        .etapa(etapa)
    );

    assign vals = {v_agua, v_cafe, v_leche, v_chocolate, v_azucar};

    always #5 clk = ~clk;

    task automatic set_t(input logic [1:0] a, b, c, d, e);
        tin[0] = a; tin[1] = b; tin[2] = c; tin[3] = d; tin[4] = e;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called just after the start edge; checks cycles 1..exp_done+1.
    task automatic check_run(input logic [1:0] t [5], input int exp_done,
                             input int cancel_cyc, input int chg_cyc,
                             input logic [1:0] tnew [5], input string nm);
        int len [5];
        int total, acc;
        logic [2:0] e_et;
        logic [4:0] e_v;
        logic e_busy, e_done;
        total = 0;
        for (int i = 0; i < 5; i++) begin
            len[i] = (t[i] != 0) ? int'(t[i]) * CPU : 1;
            total += len[i];
        end
        for (int c = 1; c <= exp_done + 1; c++) begin
            @(negedge clk);
            e_et = 3'd0;
            e_v  = 5'd0;
            acc  = 0;
            if (cancel_cyc > 0 && c > cancel_cyc) e_et = 3'd0;
            else if (c > total + 1) e_et = 3'd0;
            else if (c == total + 1) e_et = 3'd6;
            else begin
                for (int s = 0; s < 5; s++) begin
                    if (e_et == 3'd0 && c <= acc + len[s]) begin
                        e_et = 3'(s + 1);
                        if (t[s] != 0) e_v = 5'b10000 >> s;
                    end
                    acc += len[s];
                end
            end
            e_busy = (e_et != 3'd0);
            e_done = (c == exp_done) && !(cancel_cyc > 0 && c > cancel_cyc);
            n_tests++;
            if ({etapa, vals, busy, done, err} !==
                {e_et, e_v, e_busy, e_done, 1'b0}) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got etapa=%0d valves=%b busy=%b done=%b err=%b, need etapa=%0d valves=%b busy=%b done=%b err=0",
                         nm, c, etapa, vals, busy, done, err,
                         e_et, e_v, e_busy, e_done);
            end
            n_tests++;
            if ($countones(vals) > 1) begin
                n_fail++;
                $display("FAIL %s onehot cycle %0d: valves=%b, need at most one high",
                         nm, c, vals);
            end
            if (c == chg_cyc) tin = tnew;
            if (c == cancel_cyc) begin
                cancel = 1'b1;
                @(posedge clk);
                #1 cancel = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cancel = 1'b0;
        set_t(2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        repeat (2) @(negedge clk);
        n_tests++;
        if ({etapa, vals, busy, done, err} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b, need all zero",
                     {etapa, vals, busy, done, err});
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({etapa, vals, busy, done, err} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_release: got %b, need all zero",
                     {etapa, vals, busy, done, err});
        end
    endtask

    task automatic test_cancel_idle();
        set_t(2'd1, 2'd1, 2'd1, 2'd1, 2'd1);
        start = 1'b1; cancel = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; cancel = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_tests++;
            if ({etapa, busy, err} !== 5'd0) begin
                n_fail++;
                $display("FAIL cancel_idle cycle %0d: etapa=%0d busy=%b err=%b, need 0/0/0",
                         c, etapa, busy, err);
            end
        end
    endtask

    task automatic test_seq1();
        set_t(2'd2, 2'd3, 2'd0, 2'd0, 2'd1);
        pulse_start();
        check_run(tin, 27, 0, 0, tin, "seq1");
    endtask

    task automatic test_seq2();
        set_t(2'd1, 2'd1, 2'd1, 2'd2, 2'd1);
        pulse_start();
        check_run(tin, 25, 0, 0, tin, "seq2");
    endtask

    task automatic test_invalid();
        set_t(2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        pulse_start();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_tests++;
            if ({err, busy, vals, etapa} !== {(c == 1), 1'b0, 5'd0, 3'd0}) begin
                n_fail++;
                $display("FAIL invalid cycle %0d: err=%b busy=%b valves=%b etapa=%0d, need err=%b busy=0 valves=0 etapa=0",
                         c, err, busy, vals, etapa, (c == 1));
            end
        end
    endtask

    task automatic test_cancel();
        set_t(2'd2, 2'd3, 2'd0, 2'd0, 2'd1);
        pulse_start();
        check_run(tin, 27, 12, 0, tin, "cancel");
        pulse_start();
        check_run(tin, 27, 0, 0, tin, "after_cancel");
    endtask

    task automatic test_async_rst();
        set_t(2'd2, 2'd3, 2'd0, 2'd0, 2'd1);
        pulse_start();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({etapa, v_agua} !== {3'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_rst: etapa=%0d v_agua=%b, need 1/1", etapa, v_agua);
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({etapa, vals, busy, done, err} !== 11'd0) begin
            n_fail++;
            $display("FAIL async_rst: got %b, need all zero without edge",
                     {etapa, vals, busy, done, err});
        end
        @(negedge clk);
        rst = 1'b0;
        set_t(2'd2, 2'd0, 2'd0, 2'd0, 2'd0);
        pulse_start();
        check_run(tin, 13, 0, 0, tin, "post_rst");
    endtask

    task automatic test_back_to_back();
        logic [1:0] t1 [5];
        logic [1:0] t2 [5];
        t1 = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        t2 = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd1};
        tin = t1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check_run(t1, 21, 0, 5, t2, "hold_run1");
        @(posedge clk);
        #1 start = 1'b0;
        check_run(t2, 16, 0, 0, t2, "hold_run2");
    endtask

    initial begin
        test_reset();
        test_cancel_idle();
        test_seq1();
        test_seq2();
        test_invalid();
        test_cancel();
        test_async_rst();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_dispensado.md
Name: control_dispensado

Overview:
Sequencer directly downstream of the drink-time selector. On a start request it latches the five per-ingredient times (in time units) presented by the selector. It then drives the ingredient valves one at a time in fixed order: agua, cafe, leche, chocolate, azucar. A unit is CYCLES_PER_UNIT clock cycles, timed by an internal prescaler.

Parameters:
CYCLES_PER_UNIT, 50_000_000, clock cycles per time unit (1 s at 50 MHz); legal range >= 1; the bench uses 4.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  level-sampled request; acted on only in IDLE
cancel  input  1  abort current sequence
t_agua  input  2  agua time in units (0..3) from selector
t_cafe  input  2  cafe time in units
t_leche  input  2  leche time in units
t_chocolate  input  2  chocolate time in units
t_azucar  input  2  azucar time in units
v_agua  output  1  agua valve enable
v_cafe  output  1  cafe valve enable
v_leche  output  1  leche valve enable
v_chocolate  output  1  chocolate valve enable
v_azucar  output  1  azucar valve enable
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at sequence completion
err  output  1  one-cycle pulse when start is rejected
etapa  output  3  current state code

Behaviour:
- Reset (async, rst=1): state IDLE; all counters 0; all valves, busy, done and err at 0; etapa=0. These values hold while rst is high, including mid-sequence.
- State codes: IDLE=0, AGUA=1, CAFE=2, LECHE=3, CHOCOLATE=4, AZUCAR=5, DONE=6. Code 7 is unused; if it is ever reached, return to IDLE on the next edge.
- All outputs are decoded from registered state/flags only; there are no combinational input-to-output paths.
- IDLE, start=1 and at least one t_* nonzero:
  - latch all five times into internal registers;
  - next state AGUA.
  - Times are not re-sampled until the next accepted start.
- IDLE, start=1 and all t_* = 0 (invalid selection): stay in IDLE and pulse err for exactly one cycle starting the next cycle.
- Stage timing with latched time T:
  - T>0: stage lasts exactly T*CYCLES_PER_UNIT cycles; its valve is high for every one of those cycles.
  - T=0: stage lasts exactly 1 cycle with its valve low.
  - Implementation: a prescaler counts 0..CYCLES_PER_UNIT-1 and a unit counter counts 0..T-1. The stage advances when both are at terminal value; both counters clear on every stage entry.
- At most one valve is high in any cycle. Valves switch between consecutive stages with no gap cycle and no overlap.
- AZUCAR end -> DONE. DONE lasts 1 cycle with done=1 and busy=1, then IDLE.
- Latency: start sampled at edge N -> etapa=1 and v_agua=1 (if t_agua>0) from cycle N+1.
- start while busy: ignored. Holding start high continuously re-triggers from IDLE on the cycle after DONE.
- cancel=1 in any non-IDLE state (including DONE):
  - next state IDLE; all valves 0 next cycle; counters cleared;
  - no done pulse;
  - cancel has priority over stage advance.
- cancel in IDLE: no effect. cancel and start together in IDLE: cancel wins, start ignored.
- Changes on t_* inputs during a sequence have no effect.

Test Plan:
1. CYCLES_PER_UNIT=4, times 2,3,0,0,1, start pulsed at edge 0 -> cycles 1-8 v_agua; 9-20 v_cafe; 21 etapa=3 with valves low; 22 etapa=4 with valves low; 23-26 v_azucar; 27 done=1; 28 IDLE, busy=0.
2. Times 1,1,1,2,1 -> valve windows 4,4,4,8,4 cycles in order; done at cycle 25; the one-hot valve check holds every cycle.
3. All times 0 with start -> err=1 for one cycle, busy stays 0, no valve ever high.
4. Cancel asserted in cycle 12 of scenario 1 (cafe active) -> cycle 13 IDLE, all valves 0, done never pulses; a new start afterwards runs the full sequence correctly.
5. rst asserted asynchronously mid-AGUA -> outputs 0 immediately, without waiting for a clk edge; after release, IDLE with no residual count (a new start yields an exact 8-cycle agua window).
6. start held high and t_* changed mid-sequence -> latched times are used throughout; the second run starts the cycle after DONE and uses the new t_* values.
